// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and constants for the FIFO write-port arbiter.
//   arb_state_e : arbiter FSM states (ARB_IDLE, ARB_BURST)
//   STAT_W      : width of each per-requester beat counter, used only when
//                 the design is built with ARB_STATS_EN defined
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  localparam int STAT_W = 16;

endpackage : fifo_arb_pkg

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Scans the request vector starting at
// last_grant_i+1, wrapping modulo NUM_REQ, and returns the first set index.
// The wrap is done by subtraction rather than bit truncation, so indices at
// or above NUM_REQ are never visited when NUM_REQ is not a power of two.
//
// Ports:
//   req_i        in  NUM_REQ  request vector
//   last_grant_i in  IDX_W    index granted most recently
//   found_o      out 1        at least one request is set
//   idx_o        out IDX_W    chosen index (0 when found_o is low)
// -----------------------------------------------------------------------------
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);

  int cand;

  // Walk the offsets from farthest to nearest so that the nearest valid
  // requester after last_grant_i is the one that wins the final assignment.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = int'(last_grant_i) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (req_i[cand[IDX_W-1:0]]) begin
        found_o = 1'b1;
        idx_o   = cand[IDX_W-1:0];
      end
    end
  end

endmodule : rr_pick

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Shares the single write port of one FIFO among NUM_REQ producers using
// round-robin arbitration with burst lock. The owner keeps the port until it
// sends a beat with last, reaches MAX_BURST beats, or drops valid. One dead
// (IDLE) cycle separates consecutive grants.
//
// Ports:
//   clk         in  1                   clock
//   rst         in  1                   asynchronous active-high reset
//   req_valid   in  NUM_REQ             per-producer valid
//   req_last    in  NUM_REQ             per-producer last beat of burst
//   req_data    in  NUM_REQ*DATA_WIDTH  packed data, requester i at
//                                       [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready   out NUM_REQ             per-producer accept, one-hot or zero
//   fifo_full   in  1                   FIFO full flag (already registered)
//   fifo_wr_en  out 1                   FIFO write enable
//   fifo_data   out DATA_WIDTH          FIFO write data
//   grant_idx   out IDX_W               current owner index (registered)
//   busy        out 1                   high while in BURST
//   grant_count out NUM_REQ*STAT_W      only with ARB_STATS_EN: saturating
//                                       accepted-beat counter per requester
//
// Build option: define ARB_STATS_EN to add the grant_count counters.
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int IDX_W      = 2,
  parameter int BURST_W    = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic [IDX_W-1:0]              grant_idx,
  output logic                          busy
`ifdef ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]     grant_count
`endif
);

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;

  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;
  logic                 owner_valid;
  logic                 beat;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .found_o      (pick_found),
    .idx_o        (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      grant_idx_q  <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  // All FIFO-facing outputs are decoded from state_q, so an asynchronous
  // reset forces them low immediately and no partial write can leak out.
  always_comb begin
    state_d      = state_q;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_data    = '0;
    busy         = 1'b0;
    owner_valid  = 1'b0;
    beat         = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_idx_d = pick_idx;
          burst_cnt_d = '0;
          state_d     = ARB_BURST;
        end
      end

      ARB_BURST: begin
        busy                   = 1'b1;
        owner_valid            = req_valid[grant_idx_q];
        req_ready[grant_idx_q] = !fifo_full;
        fifo_data              = data_arr[grant_idx_q];
        beat                   = owner_valid && !fifo_full;
        fifo_wr_en             = beat;

        if (beat) begin
          burst_cnt_d = burst_cnt_q + BURST_W'(1);
          if (req_last[grant_idx_q] || (burst_cnt_d == BURST_W'(MAX_BURST))) begin
            state_d      = ARB_IDLE;
            last_grant_d = grant_idx_q;
          end
        end else if (!owner_valid) begin
          // Idle release. A full-FIFO stall with valid high lands in neither
          // branch, so count and grant simply hold.
          state_d      = ARB_IDLE;
          last_grant_d = grant_idx_q;
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  assign grant_idx = grant_idx_q;

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] stat_cnt_q [NUM_REQ];

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_stats
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stat_cnt_q[gi] <= '0;
        end else if (beat && (grant_idx_q == IDX_W'(gi)) &&
                     (stat_cnt_q[gi] != {STAT_W{1'b1}})) begin
          stat_cnt_q[gi] <= stat_cnt_q[gi] + STAT_W'(1);
        end
      end
      assign grant_count[gi*STAT_W +: STAT_W] = stat_cnt_q[gi];
    end
  endgenerate
`endif

endmodule : fifo_wr_arbiter

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4)
// plus a standalone rr_pick instance with NUM_REQ=3 to exercise the
// non-power-of-two wrap. Each requester drives a constant data byte 8'hA0+i.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int NR = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_last;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic          fifo_full;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_data;
  logic [1:0]    grant_idx;
  logic          busy;
`ifdef ARB_STATS_EN
  logic [NR*STAT_W-1:0] grant_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4), .IDX_W(2), .BURST_W(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_data  (fifo_data),
    .grant_idx  (grant_idx),
    .busy       (busy)
`ifdef ARB_STATS_EN
    ,
    .grant_count(grant_count)
`endif
  );

  // Standalone picker with 3 requesters: wrap must skip index 3.
  logic [2:0] p3_req;
  logic [1:0] p3_last;
  logic       p3_found;
  logic [1:0] p3_idx;

  rr_pick #(.NUM_REQ(3), .IDX_W(2)) u_pick3 (
    .req_i        (p3_req),
    .last_grant_i (p3_last),
    .found_o      (p3_found),
    .idx_o        (p3_idx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the outputs of the current cycle, print one line, then advance
  // to 1 time unit after the next rising edge.
  task automatic cyc(input string tag, input logic wr, input logic [7:0] data,
                     input logic [3:0] rdy, input logic [1:0] gidx, input logic bsy);
    #1;
    chk({tag, ".wr_en"}, 32'(fifo_wr_en), 32'(wr));
    chk({tag, ".data"},  32'(fifo_data),  32'(data));
    chk({tag, ".ready"}, 32'(req_ready),  32'(rdy));
    chk({tag, ".grant"}, 32'(grant_idx),  32'(gidx));
    chk({tag, ".busy"},  32'(busy),       32'(bsy));
    $display("%0t %s wr_en=%0b data=%02h ready=%04b grant=%0d busy=%0b",
             $time, tag, fifo_wr_en, fifo_data, req_ready, grant_idx, busy);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset.wr_en", 32'(fifo_wr_en), 32'd0);
    chk("reset.busy",  32'(busy),       32'd0);
    chk("reset.grant", 32'(grant_idx),  32'd0);
`ifdef ARB_STATS_EN
    chk("reset.stats", 32'(grant_count[31:0]) | 32'(grant_count[63:32]), 32'd0);
`endif
    rst = 1'b0;
  endtask

  initial begin
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    p3_req   = '0;
    p3_last  = '0;

    // ---- Test 1: requesters 0 and 2, full MAX_BURST bursts -----------------
    do_reset();
    req_valid = 4'b0101;
    cyc("t1.idle0", 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0);
    for (int b = 0; b < 4; b++) cyc($sformatf("t1.r0b%0d", b), 1'b1, 8'hA0, 4'b0001, 2'd0, 1'b1);
    cyc("t1.idle1", 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0);
    for (int b = 0; b < 4; b++) cyc($sformatf("t1.r2b%0d", b), 1'b1, 8'hA2, 4'b0100, 2'd2, 1'b1);
    cyc("t1.idle2", 1'b0, 8'h00, 4'b0000, 2'd2, 1'b0);
    cyc("t1.r0again", 1'b1, 8'hA0, 4'b0001, 2'd0, 1'b1);
`ifdef ARB_STATS_EN
    chk("t1.stats0", 32'(grant_count[15:0]),  32'd5);
    chk("t1.stats2", 32'(grant_count[47:32]), 32'd4);
    chk("t1.stats1", 32'(grant_count[31:16]), 32'd0);
`endif

    // ---- Test 2: all valid, last on beat 2 -> order 0,1,2,3,0 -------------
    do_reset();
    req_valid = 4'b1111;
    begin
      logic [1:0] order [5];
      order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      for (int g = 0; g < 5; g++) begin
        req_last = 4'b0000;
        cyc($sformatf("t2.idle%0d", g), 1'b0, 8'h00, 4'b0000,
            (g == 0) ? 2'd0 : order[g-1], 1'b0);
        cyc($sformatf("t2.g%0d.b0", g), 1'b1, 8'hA0 + 8'(order[g]),
            4'(1 << order[g]), order[g], 1'b1);
        req_last = 4'b1111;
        cyc($sformatf("t2.g%0d.b1", g), 1'b1, 8'hA0 + 8'(order[g]),
            4'(1 << order[g]), order[g], 1'b1);
      end
      req_last = 4'b0000;
    end

    // ---- Test 3: requester 1 stalled by fifo_full for 3 cycles ------------
    do_reset();
    req_valid = 4'b0010;
    cyc("t3.idle", 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0);
    cyc("t3.b0",   1'b1, 8'hA1, 4'b0010, 2'd1, 1'b1);
    fifo_full = 1'b1;
    for (int s = 0; s < 3; s++) cyc($sformatf("t3.stall%0d", s), 1'b0, 8'hA1, 4'b0000, 2'd1, 1'b1);
    fifo_full = 1'b0;
    for (int b = 1; b < 4; b++) cyc($sformatf("t3.b%0d", b), 1'b1, 8'hA1, 4'b0010, 2'd1, 1'b1);
    req_valid = 4'b0000;
    cyc("t3.done", 1'b0, 8'h00, 4'b0000, 2'd1, 1'b0);

    // ---- Test 4: owner 1 drops valid after 1 beat, requester 3 waiting ----
    do_reset();
    req_valid = 4'b1010;
    cyc("t4.idle0", 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0);
    cyc("t4.r1b0",  1'b1, 8'hA1, 4'b0010, 2'd1, 1'b1);
    req_valid = 4'b1000;
    cyc("t4.r1drop", 1'b0, 8'hA1, 4'b0010, 2'd1, 1'b1);
    cyc("t4.idle1", 1'b0, 8'h00, 4'b0000, 2'd1, 1'b0);
    cyc("t4.r3b0",  1'b1, 8'hA3, 4'b1000, 2'd3, 1'b1);

    // ---- Test 5: reset asserted mid-burst ---------------------------------
    do_reset();
    req_valid = 4'b0100;
    cyc("t5.idle", 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0);
    cyc("t5.b0",   1'b1, 8'hA2, 4'b0100, 2'd2, 1'b1);
    #1;
    chk("t5.b1.wr_en", 32'(fifo_wr_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("t5.async.wr_en", 32'(fifo_wr_en), 32'd0);
    chk("t5.async.ready", 32'(req_ready),  32'd0);
    chk("t5.async.busy",  32'(busy),       32'd0);
    chk("t5.async.grant", 32'(grant_idx),  32'd0);
    chk("t5.async.data",  32'(fifo_data),  32'd0);
    $display("%0t t5.async wr_en=%0b ready=%04b grant=%0d busy=%0b",
             $time, fifo_wr_en, req_ready, grant_idx, busy);
    @(posedge clk);
    #1;
    chk("t5.held.wr_en", 32'(fifo_wr_en), 32'd0);
    rst = 1'b0;
    req_valid = 4'b0101;
    cyc("t5.post.idle", 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0);
    cyc("t5.post.r0",   1'b1, 8'hA0, 4'b0001, 2'd0, 1'b1);

    // ---- rr_pick with NUM_REQ=3 ------------------------------------------
    p3_req = 3'b001; p3_last = 2'd2; #1;
    chk("p3.wrap.found", 32'(p3_found), 32'd1);
    chk("p3.wrap.idx",   32'(p3_idx),   32'd0);
    $display("%0t p3 req=%03b last=%0d found=%0b idx=%0d", $time, p3_req, p3_last, p3_found, p3_idx);
    p3_req = 3'b100; p3_last = 2'd2; #1;
    chk("p3.self.idx",   32'(p3_idx),   32'd2);
    $display("%0t p3 req=%03b last=%0d found=%0b idx=%0d", $time, p3_req, p3_last, p3_found, p3_idx);
    p3_req = 3'b011; p3_last = 2'd1; #1;
    chk("p3.next.idx",   32'(p3_idx),   32'd0);
    $display("%0t p3 req=%03b last=%0d found=%0b idx=%0d", $time, p3_req, p3_last, p3_found, p3_idx);
    p3_req = 3'b000; p3_last = 2'd0; #1;
    chk("p3.none.found", 32'(p3_found), 32'd0);
    $display("%0t p3 req=%03b last=%0d found=%0b idx=%0d", $time, p3_req, p3_last, p3_found, p3_idx);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fifo_wr_arbiter

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Shares the single write port of one fifoArray instance among NUM_REQ producers, e.g. butterfly-stage outputs. Round-robin arbitration with burst lock: the granted producer keeps the port until it signals last, hits MAX_BURST, or goes idle. Sits between producer valid/ready interfaces and the FIFO's wr_en/data_in/full pins. Write-side only; the FIFO's read side is untouched.

Parameters:
NUM_REQ, 4, number of producers (>=2)
DATA_WIDTH, 8, data bus width; matches the FIFO
MAX_BURST, 4, maximum beats per grant (>=1)
IDX_W, 2, width of the requester index, equal to clog2(NUM_REQ)
BURST_W, 3, width of the burst counter, equal to clog2(MAX_BURST)+1

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-producer data valid
req_last  in  NUM_REQ  per-producer last beat of burst
req_data  in  NUM_REQ*DATA_WIDTH  packed data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  NUM_REQ  per-producer accept, one-hot or zero
fifo_full  in  1  FIFO full flag
fifo_wr_en  out  1  FIFO write enable
fifo_data  out  DATA_WIDTH  FIFO write data
grant_idx  out  IDX_W  current owner index (registered)
busy  out  1  high while in BURST

Behaviour:
- Reset: state IDLE, grant_idx=0, last_grant=NUM_REQ-1 (requester 0 wins first), burst_cnt=0. fifo_wr_en=0, req_ready=0, busy=0, fifo_data=0.
- IDLE:
  - If any req_valid is high, select the first valid requester scanning from last_grant+1 with wrap modulo NUM_REQ.
  - Register the choice into grant_idx, clear burst_cnt, go to BURST.
  - Arbitration latency is 1 cycle; no beat transfers in IDLE.
- BURST, combinational toward the FIFO (fifo_full is already registered there):
  - req_ready[grant_idx] = !fifo_full; all other req_ready bits are 0.
  - fifo_wr_en = req_valid[grant_idx] && !fifo_full.
  - fifo_data = req_data slice of grant_idx.
  - A beat is accepted when valid && ready; burst_cnt increments on each accepted beat.
- BURST exit to IDLE, with last_grant <= grant_idx, when any of these holds:
  - an accepted beat has req_last=1;
  - an accepted beat makes burst_cnt reach MAX_BURST;
  - the owner's req_valid is low for a cycle (idle release).
- Back-to-back: after exit, IDLE re-arbitrates next cycle. There is one dead cycle between grants, so peak throughput is MAX_BURST/(MAX_BURST+1).
- fifo_full during BURST: stall. No beat, burst_cnt holds, grant holds, the stall does not count as idle release.
- Non-owners with valid high wait with req_ready=0; their data must stay stable (producer rule).
- Reset mid-burst: immediate abort to reset values; the FIFO never sees a partial wr_en.
- NUM_REQ not a power of two: the wrap skips unused indices.

Optional Feature:
ARB_STATS_EN
- Defined: adds output port grant_count (NUM_REQ*16 bits) holding one 16-bit counter per requester. A counter increments on each accepted beat of that requester, saturates at 16'hFFFF, and resets to 0.
- Undefined: the port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fifo_arb_pkg: state enum (ARB_IDLE, ARB_BURST), STAT_W=16 constant.
- Sub-module rr_pick: combinational round-robin picker. Inputs are the request vector and last_grant; outputs are a found flag and the index. It is unit-testable standalone.

Test Plan:
- Reset, then req_valid=4'b0101, no last, MAX_BURST=4 -> requester 0 granted at cycle 1 and writes 4 beats. Requester 2 granted after 1 dead cycle and writes 4 beats, then 0 again.
- All 4 requesters valid, each sends last on beat 2 -> grant order 0,1,2,3,0. Each burst is 2 fifo_wr_en pulses.
- Requester 1 owns the grant, fifo_full=1 for 3 cycles mid-burst -> fifo_wr_en=0 and req_ready=0 for those 3 cycles. burst_cnt and grant hold, and the burst resumes to complete MAX_BURST beats total.
- Owner drops req_valid after 1 beat while requester 3 is waiting -> return to IDLE, then requester 3 is granted. FIFO sees exactly 1 beat from the owner.
- rst asserted mid-burst (beat 2 of 4) -> all outputs 0 asynchronously. After release, requester 0 has priority and no stray wr_en occurs.
- ARB_STATS_EN, requester 2 streams 70000 accepted beats -> grant_count[2] saturates at 65535 and the other counters read 0.
